alu_sched: RTL
==============

ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 Parameter STARVE_MAX, default 4: consecutive requester-A wins with B pending before B is forced to win.
REQ-002 Parameter OP_W, default 4: ALU opcode width, equal to the codebase ALU opcode bus width.
REQ-003 Parameter DATA_W, default 16: operand and result width.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 req_a_i  in  1  requester A (pipeline EX) wants an ALU operation.
REQ-007 op_a_i / opnd1_a_i / opnd2_a_i  in  OP_W / DATA_W / DATA_W  requester A opcode and operands.
REQ-008 req_b_i, op_b_i, opnd1_b_i, opnd2_b_i  in  1 / OP_W / DATA_W / DATA_W  requester B (auxiliary unit), same meaning.
REQ-009 flush_i  in  1  cancel requester A's pending or in-flight operation.
REQ-010 alu_op_o / alu_opnd1_o / alu_opnd2_o  out  OP_W / DATA_W / DATA_W  drive to the shared combinational ALU.
REQ-011 alu_res_i  in  DATA_W  ALU result, combinational in the drive values.
REQ-012 gnt_a_o, gnt_b_o  out  1 each  request accepted at the previous edge.
REQ-013 done_a_o, done_b_o  out  1 each  one-cycle result-valid pulse.
REQ-014 res_o  out  DATA_W  captured result, valid while either done is high.
REQ-015 stall_a_o  out  1  requester A is not being accepted this cycle.

Function
REQ-016 State machine: IDLE and EXEC; owner register (A/B) and 3-bit starvation counter.
REQ-017 Arbitration occurs only in IDLE.
  - Only one request: it wins.
  - Both requests: A wins, unless the starvation counter equals STARVE_MAX, then B wins.
REQ-018 flush_i high in IDLE: req_a_i is ignored for that cycle, and B may win.
REQ-019 On an IDLE edge with a winner:
  - latch winner's op and operands into internal registers;
  - set owner;
  - move to EXEC.
  - With no winner, stay in IDLE.
REQ-020 In EXEC, gnt of the owner is high, and the ALU outputs are driven from the latched registers.
REQ-021 At the end of EXEC:
  - alu_res_i is captured into res_o;
  - state returns to IDLE;
  - in that IDLE cycle, done of the owner pulses high for exactly one cycle.
  - Latency is request sampled at edge N, gnt at N+1, done at N+2.
  - Throughput is one operation per 2 cycles.
REQ-022 In IDLE, alu_op_o, alu_opnd1_o and alu_opnd2_o hold their last latched values; res_o holds until the next capture.
REQ-023 A request held high after its gnt is a new request and is arbitrated again in the following IDLE cycle.
REQ-024 stall_a_o = req_a_i AND NOT (state IDLE AND A wins this cycle); it is combinational.
REQ-025 flush_i high during EXEC with owner A: done_a_o is suppressed in the next cycle, and res_o is still captured.
REQ-026 flush_i has no effect on a B operation.
REQ-027 Starvation counter:
  - increments, saturating at STARVE_MAX, when A wins while req_b_i is high;
  - clears when B wins or when req_b_i is low in IDLE;
  - holds otherwise.
REQ-028 gnt and done of A and B are never high simultaneously; at most one operation is in flight.

Reset
REQ-029 rst low forces immediately, regardless of clk:
  - state IDLE, owner A, starvation counter 0;
  - all gnt/done outputs 0;
  - res_o, alu_op_o, alu_opnd1_o, alu_opnd2_o all 0.
REQ-030 Reset asserted mid-EXEC discards the operation; no done pulse follows reset release.
REQ-031 The first arbitration is on the first rising edge after rst returns high.

Verification
REQ-032 Single A: req_a with ADD, 0x0003, 0x0004; ALU model op1+op2 -> gnt_a at N+1, done_a at N+2 with res_o=0x0007, stall_a_o low at N.
REQ-033 Contention: req_a and req_b held continuously, STARVE_MAX=4 -> grant order A,A,A,A,B,A,A,A,A,B; done pulses are 2 cycles apart.
REQ-034 Stall: req_b alone wins at N, req_a rises at N+1 -> stall_a_o high during EXEC, A granted at N+3.
REQ-035 Flush: A accepted with operands 0x8000, 0x0001; flush_i high in EXEC -> no done_a, res_o=0x8001 captured, next A request arbitrated normally.
REQ-036 Reset mid-op: rst low during EXEC of B -> outputs 0 immediately, no done_b after release, counter 0.

Source files
------------

// File: rtl/alu_sched_if.sv
// Requester / shared-ALU bundle for alu_sched. The slave side is the scheduler,
// the master side is the surrounding pipeline, auxiliary unit and ALU.
interface alu_sched_if #(
  parameter int OP_W   = 4,
  parameter int DATA_W = 16
);
  logic              req_a_i;
  logic [OP_W-1:0]   op_a_i;
  logic [DATA_W-1:0] opnd1_a_i;
  logic [DATA_W-1:0] opnd2_a_i;
  logic              req_b_i;
  logic [OP_W-1:0]   op_b_i;
  logic [DATA_W-1:0] opnd1_b_i;
  logic [DATA_W-1:0] opnd2_b_i;
  logic              flush_i;
  logic [OP_W-1:0]   alu_op_o;
  logic [DATA_W-1:0] alu_opnd1_o;
  logic [DATA_W-1:0] alu_opnd2_o;
  logic [DATA_W-1:0] alu_res_i;
  logic              gnt_a_o;
  logic              gnt_b_o;
  logic              done_a_o;
  logic              done_b_o;
  logic [DATA_W-1:0] res_o;
  logic              stall_a_o;

  modport slave (
    input  req_a_i, op_a_i, opnd1_a_i, opnd2_a_i,
    input  req_b_i, op_b_i, opnd1_b_i, opnd2_b_i,
    input  flush_i, alu_res_i,
    output alu_op_o, alu_opnd1_o, alu_opnd2_o,
    output gnt_a_o, gnt_b_o, done_a_o, done_b_o, res_o, stall_a_o
  );

  modport master (
    output req_a_i, op_a_i, opnd1_a_i, opnd2_a_i,
    output req_b_i, op_b_i, opnd1_b_i, opnd2_b_i,
    output flush_i, alu_res_i,
    input  alu_op_o, alu_opnd1_o, alu_opnd2_o,
    input  gnt_a_o, gnt_b_o, done_a_o, done_b_o, res_o, stall_a_o
  );
endinterface

// File: rtl/alu_sched.sv
// Two-requester scheduler for one shared combinational ALU: A has priority,
// B is forced through after STARVE_MAX consecutive A wins while it waits.
module alu_sched #(
  parameter int STARVE_MAX = 4,
  parameter int OP_W       = 4,
  parameter int DATA_W     = 16
) (
  input logic        clk,
  input logic        rst,
  alu_sched_if.slave bus
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] EXEC  = 1'b1;
  localparam logic       OWN_A = 1'b0;
  localparam logic       OWN_B = 1'b1;

  logic [0:0]        state;
  logic              owner;
  logic [2:0]        starve;
  logic              done_a, done_b;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] x_q, y_q, res_q;
  logic              cand_a, starved, win_a, win_b;

  // A is masked by flush; B overrides A only once A has starved it.
  always_comb begin
    cand_a  = bus.req_a_i & ~bus.flush_i;
    starved = (starve == 3'(STARVE_MAX));
    win_a   = (state == IDLE) & cand_a & ~(bus.req_b_i & starved);
    win_b   = (state == IDLE) & bus.req_b_i & ~win_a;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      owner  <= OWN_A;
      starve <= '0;
      done_a <= 1'b0;
      done_b <= 1'b0;
      op_q   <= '0;
      x_q    <= '0;
      y_q    <= '0;
      res_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_a <= 1'b0;
          done_b <= 1'b0;
          if (win_b || !bus.req_b_i)
            starve <= '0;
          else if (win_a && !starved)
            starve <= starve + 3'd1;
          if (win_a || win_b) begin
            state <= EXEC;
            owner <= win_b ? OWN_B : OWN_A;
            op_q  <= win_b ? bus.op_b_i    : bus.op_a_i;
            x_q   <= win_b ? bus.opnd1_b_i : bus.opnd1_a_i;
            y_q   <= win_b ? bus.opnd2_b_i : bus.opnd2_a_i;
          end
        end
        default: begin
          // Result is captured even when a flush drops A's completion pulse.
          res_q  <= bus.alu_res_i;
          done_a <= (owner == OWN_A) & ~bus.flush_i;
          done_b <= (owner == OWN_B);
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.alu_op_o    = op_q;
  assign bus.alu_opnd1_o = x_q;
  assign bus.alu_opnd2_o = y_q;
  assign bus.res_o       = res_q;
  assign bus.gnt_a_o     = (state == EXEC) & (owner == OWN_A);
  assign bus.gnt_b_o     = (state == EXEC) & (owner == OWN_B);
  assign bus.done_a_o    = done_a;
  assign bus.done_b_o    = done_b;
  assign bus.stall_a_o   = bus.req_a_i & ~win_a;
endmodule
